// File: rtl/load_store_unit_if.sv
// CPU-side request/response and DataMemory signals of the load/store unit.
interface load_store_unit_if;
  logic        ReqValid;
  logic        ReqReady;
  logic [2:0]  MemOp;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        Done;
  logic [31:0] RData;
  logic        AlignErr;
  logic        mRD;
  logic        mWR;
  logic [31:0] DataAddr;
  logic [31:0] DataIn;
  logic [31:0] MemDataOut;

  // The load/store unit itself
  modport slave (
    input  ReqValid, MemOp, Addr, WData, MemDataOut,
    output ReqReady, Done, RData, AlignErr, mRD, mWR, DataAddr, DataIn
  );

  // CPU + memory side that drives requests and returns read data
  modport master (
    output ReqValid, MemOp, Addr, WData, MemDataOut,
    input  ReqReady, Done, RData, AlignErr, mRD, mWR, DataAddr, DataIn
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: turns byte/half/word loads and stores into word-wide
// DataMemory accesses, with read-modify-write for sub-word stores.
module load_store_unit #(
  parameter bit BIG_ENDIAN = 1'b1,
  parameter bit WORD_INDEX = 1'b1
) (
  input logic               CLK,
  input logic               Reset,
  load_store_unit_if.slave  bus
);

  localparam logic [2:0] OpLb  = 3'd0;
  localparam logic [2:0] OpLh  = 3'd1;
  localparam logic [2:0] OpLw  = 3'd2;
  localparam logic [2:0] OpLbu = 3'd3;
  localparam logic [2:0] OpLhu = 3'd4;
  localparam logic [2:0] OpSb  = 3'd5;
  localparam logic [2:0] OpSh  = 3'd6;
  localparam logic [2:0] OpSw  = 3'd7;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q, word_q, rdata_q;
  logic        err_q;

  logic        accept, misaligned, is_load;
  logic [4:0]  byte_sh, half_sh;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_val, mask, ins, merged, word_addr;

  assign accept  = bus.ReqValid && (state_q == StIdle);
  assign is_load = (op_q <= OpLhu);

  // Alignment check on the incoming request
  always_comb begin
    misaligned = 1'b0;
    case (bus.MemOp)
      OpLh, OpLhu, OpSh: misaligned = bus.Addr[0];
      OpLw, OpSw:        misaligned = |bus.Addr[1:0];
      default:           misaligned = 1'b0;
    endcase
  end

  // Lane offsets within the word; big-endian puts offset 0 at the top byte
  always_comb begin
    if (BIG_ENDIAN) begin
      byte_sh = {~addr_q[1:0], 3'b000};
      half_sh = {~addr_q[1], 4'b0000};
    end else begin
      byte_sh = {addr_q[1:0], 3'b000};
      half_sh = {addr_q[1], 4'b0000};
    end
    word_addr = WORD_INDEX ? {2'b00, addr_q[31:2]} : {addr_q[31:2], 2'b00};
  end

  // Load lane extraction with sign/zero extension
  always_comb begin
    byte_val = bus.MemDataOut[byte_sh +: 8];
    half_val = bus.MemDataOut[half_sh +: 16];
    case (op_q)
      OpLb:    load_val = {{24{byte_val[7]}}, byte_val};
      OpLbu:   load_val = {24'b0, byte_val};
      OpLh:    load_val = {{16{half_val[15]}}, half_val};
      OpLhu:   load_val = {16'b0, half_val};
      default: load_val = bus.MemDataOut;
    endcase
  end

  // Sub-word merge into the word captured during the read phase
  always_comb begin
    if (op_q == OpSb) begin
      mask = 32'h0000_00ff << byte_sh;
      ins  = {24'b0, wdata_q[7:0]} << byte_sh;
    end else begin
      mask = 32'h0000_ffff << half_sh;
      ins  = {16'b0, wdata_q[15:0]} << half_sh;
    end
    merged = (word_q & ~mask) | ins;
  end

  // State register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (misaligned)             state_d = StDone;
          else if (bus.MemOp == OpSw) state_d = StWr;
          else                        state_d = StRd;
        end
      end
      StRd:    state_d = is_load ? StDone : StWr;
      StWr:    state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode straight from state so reset kills mRD/mWR at once
  always_comb begin
    bus.ReqReady = (state_q == StIdle);
    bus.mRD      = (state_q == StRd);
    bus.mWR      = (state_q == StWr);
    bus.Done     = (state_q == StDone);
    bus.AlignErr = (state_q == StDone) && err_q;
    bus.RData    = rdata_q;
    bus.DataAddr = 32'b0;
    bus.DataIn   = 32'b0;
    if (state_q == StRd || state_q == StWr) bus.DataAddr = word_addr;
    if (state_q == StWr) bus.DataIn = (op_q == OpSw) ? wdata_q : merged;
  end

  // Request latch, read-word capture and load result register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      op_q    <= 3'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      err_q   <= 1'b0;
      word_q  <= 32'b0;
      rdata_q <= 32'b0;
    end else begin
      if (accept) begin
        op_q    <= bus.MemOp;
        addr_q  <= bus.Addr;
        wdata_q <= bus.WData;
        err_q   <= misaligned;
      end
      if (state_q == StRd) begin
        word_q <= bus.MemDataOut;
        if (is_load) rdata_q <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit (BIG_ENDIAN=1, WORD_INDEX=1).
module tb_load_store_unit;

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3;
  localparam logic [2:0] LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] din;
    logic [31:0] daddr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.BIG_ENDIAN(1'b1), .WORD_INDEX(1'b1)) dut (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [64];
  assign bus.MemDataOut = mem[bus.DataAddr[5:0]];
  always @(negedge clk) if (bus.mWR) mem[bus.DataAddr[5:0]] = bus.DataIn;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_mis = 0;
  logic [31:0] held_rdata = 32'b0;

  int          obs_lat, obs_rd, obs_wr;
  logic        obs_done, obs_err, obs_ready;
  logic [31:0] obs_rdata, obs_din, obs_daddr;

  // Issue one request in an IDLE cycle and watch it until Done (bounded)
  task automatic run_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    obs_ready    = bus.ReqReady;
    bus.ReqValid = 1'b1;
    bus.MemOp    = op;
    bus.Addr     = a;
    bus.WData    = wd;
    @(posedge clk);
    #1 bus.ReqValid = 1'b0;
    obs_lat = 0; obs_rd = 0; obs_wr = 0; obs_done = 1'b0;
    obs_din = 32'b0; obs_daddr = 32'b0; obs_rdata = 32'b0; obs_err = 1'b0;
    for (int i = 0; i < 8 && !obs_done; i++) begin
      @(negedge clk);
      obs_lat++;
      if (bus.mRD) begin obs_rd++; obs_daddr = bus.DataAddr; end
      if (bus.mWR) begin obs_wr++; obs_din = bus.DataIn; obs_daddr = bus.DataAddr; end
      if (bus.Done) begin
        obs_done  = 1'b1;
        obs_rdata = bus.RData;
        obs_err   = bus.AlignErr;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({bus.ReqReady, bus.Done, bus.AlignErr, bus.mRD, bus.mWR} !== 5'b10000) begin
      n_mis++;
      $display("FAIL reset_ctrl got %b want 10000",
               {bus.ReqReady, bus.Done, bus.AlignErr, bus.mRD, bus.mWR});
    end
    n_vec++;
    if ({bus.RData, bus.DataAddr, bus.DataIn} !== 96'b0) begin
      n_mis++;
      $display("FAIL reset_data got RData=%h DataAddr=%h DataIn=%h want 0",
               bus.RData, bus.DataAddr, bus.DataIn);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_loads();
    logic [2:0]  ops [8];
    logic [31:0] adr [8];
    logic [31:0] res [8];
    exp_t e;
    ops = '{LB, LBU, LH, LHU, LB, LW, LBU, LH};
    adr = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h10, 32'h10, 32'h11, 32'h12};
    res = '{32'hFFFFFFF4, 32'h000000F4, 32'hFFFFA1B2, 32'h0000C3F4,
            32'hFFFFFFA1, 32'hA1B2C3F4, 32'h000000B2, 32'hFFFFC3F4};
    mem[4] = 32'hA1B2C3F4;
    for (int i = 0; i < 8; i++) begin
      e = '{rdata: res[i], err: 1'b0, lat: 2, rd: 1, wr: 0, din: 32'b0, daddr: adr[i] >> 2};
      sb.push_back(e);
      held_rdata = res[i];
      run_req(ops[i], adr[i], 32'hCAFE0000);
      e = sb.pop_front();
      n_vec++;
      if (!obs_done || obs_lat != e.lat || obs_rd != e.rd || obs_wr != e.wr || !obs_ready) begin
        n_mis++;
        $display("FAIL load%0d_timing got lat=%0d rd=%0d wr=%0d done=%b ready=%b want lat=%0d rd=%0d wr=%0d",
                 i, obs_lat, obs_rd, obs_wr, obs_done, obs_ready, e.lat, e.rd, e.wr);
      end
      n_vec++;
      if (obs_rdata !== e.rdata || obs_err !== e.err || obs_daddr !== e.daddr) begin
        n_mis++;
        $display("FAIL load%0d_data got RData=%h err=%b addr=%h want %h %b %h",
                 i, obs_rdata, obs_err, obs_daddr, e.rdata, e.err, e.daddr);
      end
    end
  endtask

  task automatic test_stores();
    logic [2:0]  ops [8];
    logic [31:0] adr [8];
    logic [31:0] wd  [8];
    logic [31:0] val [8];
    exp_t e;
    ops = '{SB, LW, SH, SB, SH, LW, SW, LW};
    adr = '{32'h12, 32'h10, 32'h12, 32'h10, 32'h10, 32'h10, 32'h20, 32'h20};
    wd  = '{32'h000000EE, 32'h0, 32'hFFFF5566, 32'h00000099, 32'h0000ABCD, 32'h0,
            32'hDEADBEEF, 32'h0};
    val = '{32'h1122EE44, 32'h1122EE44, 32'h11225566, 32'h99225566, 32'hABCD5566,
            32'hABCD5566, 32'hDEADBEEF, 32'hDEADBEEF};
    mem[4] = 32'h11223344;
    mem[8] = 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (ops[i] <= LHU) begin
        held_rdata = val[i];
        e = '{rdata: val[i], err: 1'b0, lat: 2, rd: 1, wr: 0, din: 32'b0, daddr: adr[i] >> 2};
      end else if (ops[i] == SW) begin
        e = '{rdata: held_rdata, err: 1'b0, lat: 2, rd: 0, wr: 1, din: val[i],
              daddr: adr[i] >> 2};
      end else begin
        e = '{rdata: held_rdata, err: 1'b0, lat: 3, rd: 1, wr: 1, din: val[i],
              daddr: adr[i] >> 2};
      end
      sb.push_back(e);
      run_req(ops[i], adr[i], wd[i]);
      e = sb.pop_front();
      n_vec++;
      if (!obs_done || obs_lat != e.lat || obs_rd != e.rd || obs_wr != e.wr || !obs_ready) begin
        n_mis++;
        $display("FAIL store%0d_timing got lat=%0d rd=%0d wr=%0d done=%b ready=%b want lat=%0d rd=%0d wr=%0d",
                 i, obs_lat, obs_rd, obs_wr, obs_done, obs_ready, e.lat, e.rd, e.wr);
      end
      n_vec++;
      if (obs_rdata !== e.rdata || obs_err !== e.err || obs_din !== e.din ||
          obs_daddr !== e.daddr) begin
        n_mis++;
        $display("FAIL store%0d_data got RData=%h err=%b DataIn=%h addr=%h want %h %b %h %h",
                 i, obs_rdata, obs_err, obs_din, obs_daddr, e.rdata, e.err, e.din, e.daddr);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [2:0]  ops [6];
    logic [31:0] adr [6];
    exp_t e;
    ops = '{LH, LHU, SH, LW, SW, SW};
    adr = '{32'h13, 32'h11, 32'h11, 32'h12, 32'h22, 32'h21};
    for (int i = 0; i < 6; i++) begin
      e = '{rdata: held_rdata, err: 1'b1, lat: 1, rd: 0, wr: 0, din: 32'b0, daddr: 32'b0};
      sb.push_back(e);
      run_req(ops[i], adr[i], 32'h5A5A5A5A);
      e = sb.pop_front();
      n_vec++;
      if (!obs_done || obs_lat != e.lat || obs_rd != e.rd || obs_wr != e.wr ||
          obs_err !== e.err || obs_rdata !== e.rdata) begin
        n_mis++;
        $display("FAIL misalign%0d got lat=%0d rd=%0d wr=%0d err=%b RData=%h want 1/0/0/1/%h",
                 i, obs_lat, obs_rd, obs_wr, obs_err, obs_rdata, e.rdata);
      end
    end
    n_vec++;
    if (mem[4] !== 32'hABCD5566 || mem[8] !== 32'hDEADBEEF) begin
      n_mis++;
      $display("FAIL misalign_mem got %h %h want ABCD5566 DEADBEEF", mem[4], mem[8]);
    end
  endtask

  task automatic test_reset_mid_store();
    mem[4] = 32'h11223344;
    @(negedge clk);
    bus.ReqValid = 1'b1;
    bus.MemOp    = SH;
    bus.Addr     = 32'h10;
    bus.WData    = 32'h00007777;
    @(posedge clk);
    #1 bus.ReqValid = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.mWR !== 1'b1) begin
      n_mis++;
      $display("FAIL rst_mid_in_wr got mWR=%b want 1", bus.mWR);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.ReqReady, bus.Done, bus.AlignErr, bus.mRD, bus.mWR} !== 5'b10000) begin
      n_mis++;
      $display("FAIL rst_mid_ctrl got %b want 10000",
               {bus.ReqReady, bus.Done, bus.AlignErr, bus.mRD, bus.mWR});
    end
    n_vec++;
    if ({bus.RData, bus.DataAddr, bus.DataIn} !== 96'b0) begin
      n_mis++;
      $display("FAIL rst_mid_data got RData=%h DataAddr=%h DataIn=%h want 0",
               bus.RData, bus.DataAddr, bus.DataIn);
    end
    held_rdata = 32'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    n_vec++;
    if (mem[4] !== 32'h11223344) begin
      n_mis++;
      $display("FAIL rst_mid_mem got %h want 11223344", mem[4]);
    end
    @(negedge clk);
    n_vec++;
    if (bus.ReqReady !== 1'b1) begin
      n_mis++;
      $display("FAIL rst_mid_ready got %b want 1", bus.ReqReady);
    end
  endtask

  task automatic test_busy();
    exp_t e;
    int   busy_bad;
    e = '{rdata: 32'h11223344, err: 1'b0, lat: 2, rd: 1, wr: 0, din: 32'b0, daddr: 32'h4};
    sb.push_back(e);
    held_rdata = 32'h11223344;
    @(negedge clk);
    bus.ReqValid = 1'b1;
    bus.MemOp    = LW;
    bus.Addr     = 32'h10;
    bus.WData    = 32'h0;
    @(posedge clk);
    obs_lat = 0; obs_rd = 0; obs_wr = 0; obs_done = 1'b0; busy_bad = 0;
    for (int i = 0; i < 8 && !obs_done; i++) begin
      #1;
      bus.MemOp = (i[0]) ? SB : SW;
      bus.WData = 32'hBAD00000 | i;
      @(negedge clk);
      obs_lat++;
      if (bus.ReqReady !== 1'b0) busy_bad++;
      if (bus.mRD) obs_rd++;
      if (bus.mWR) obs_wr++;
      if (bus.Done) begin
        obs_done     = 1'b1;
        obs_rdata    = bus.RData;
        bus.ReqValid = 1'b0;
      end else begin
        @(posedge clk);
      end
    end
    bus.ReqValid = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if (!obs_done || obs_lat != e.lat || obs_rd != e.rd || obs_wr != e.wr ||
        obs_rdata !== e.rdata) begin
      n_mis++;
      $display("FAIL busy_first got lat=%0d rd=%0d wr=%0d RData=%h want 2/1/0/%h",
               obs_lat, obs_rd, obs_wr, obs_rdata, e.rdata);
    end
    n_vec++;
    if (busy_bad != 0) begin
      n_mis++;
      $display("FAIL busy_ready got %0d busy cycles with ReqReady=1 want 0", busy_bad);
    end
    @(negedge clk);
    n_vec++;
    if (bus.ReqReady !== 1'b1 || bus.mRD !== 1'b0 || bus.mWR !== 1'b0) begin
      n_mis++;
      $display("FAIL busy_idle got ready=%b mRD=%b mWR=%b want 1 0 0",
               bus.ReqReady, bus.mRD, bus.mWR);
    end
    @(negedge clk);
    n_vec++;
    if (mem[4] !== 32'h11223344 || bus.ReqReady !== 1'b1) begin
      n_mis++;
      $display("FAIL busy_mem got mem=%h ready=%b want 11223344 1", mem[4], bus.ReqReady);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'b0;
    bus.ReqValid = 1'b0;
    bus.MemOp    = 3'b0;
    bus.Addr     = 32'b0;
    bus.WData    = 32'b0;
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_reset_mid_store();
    test_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage between the CPU datapath and the word-organised DataMemory.
- Converts byte, halfword and word load/store requests into word-wide DataMemory accesses, using read-modify-write for sub-word stores.
- Extracts and sign- or zero-extends load data, detects misaligned accesses, and stalls the CPU via a ready/done handshake.

Parameters:
- BIG_ENDIAN, 1: 1 = byte offset 0 maps to word bits [31:24]; 0 = offset 0 maps to bits [7:0].
- WORD_INDEX, 1: 1 = DataAddr = {2'b00, Addr[31:2]} (word index); 0 = DataAddr = {Addr[31:2], 2'b00}.

Ports:
- CLK  in  1  system clock, rising-edge logic.
- Reset  in  1  asynchronous, active-low reset.
- ReqValid  in  1  CPU request strobe.
- ReqReady  out  1  high only in IDLE; a request is accepted on a rising edge when ReqValid & ReqReady.
- MemOp  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
- Addr  in  32  byte address.
- WData  in  32  store data; byte/half taken from the LSBs.
- Done  out  1  one-cycle completion pulse.
- RData  out  32  load result, valid while Done=1 and held until the next Done.
- AlignErr  out  1  qualifies Done: access misaligned and aborted.
- mRD  out  1  DataMemory read enable.
- mWR  out  1  DataMemory write enable; memory writes on the negedge of CLK.
- DataAddr  out  32  DataMemory word address.
- DataIn  out  32  DataMemory write data.
- MemDataOut  in  32  DataMemory DataOut; combinational read data.

Behaviour:
- Reset (async, Reset=0): state=IDLE; Done, AlignErr, RData and the latched request registers = 0. mRD and mWR drop to 0 immediately, because they decode directly from state.
- Acceptance: MemOp, Addr and WData are latched into internal registers. ReqValid outside IDLE is ignored.
- Misalignment: LH/LHU/SH with Addr[0]=1, or LW/SW with Addr[1:0]!=0. The block goes to DONE with AlignErr=1, RData unchanged, and mRD/mWR never asserted.
- States:
  - IDLE: ReqReady=1.
  - RD: mRD=1. DataAddr from the latched Addr. MemDataOut is captured at the rising edge that ends RD.
  - WR: mWR=1. DataIn holds the store word.
  - DONE: Done=1 for exactly one cycle, then IDLE.
- Transitions:
  - IDLE -> DONE on misaligned.
  - IDLE -> RD on loads, SB and SH.
  - IDLE -> WR on SW.
  - RD -> DONE on loads.
  - RD -> WR on SB/SH.
  - WR -> DONE.
- Latency in cycles from the accept edge to the Done cycle: loads 2, SW 2, SB/SH 3, misaligned 1.
- Load extraction:
  - Byte lane is selected by Addr[1:0]; halfword lane by Addr[1], per BIG_ENDIAN.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW passes the word through.
  - RData is registered at the RD->DONE edge.
- Sub-word store: the captured word has only the addressed byte or half replaced by WData[7:0] or WData[15:0]. All other bits are preserved exactly.
- SW: DataIn = latched WData.
- Idle outputs: DataAddr and DataIn are 0 in IDLE and DONE.
- Reset mid-operation: abandons the access with no partial write; a write happens only if the negedge occurs while in WR with Reset=1.
- Back-to-back requests: the earliest next accept is the edge ending DONE+1, i.e. the first IDLE cycle.

Test Plan:
- Sub-word loads: word index 4 = 0xA1B2C3F4, BIG_ENDIAN=1.
  - LB Addr=0x13 -> Done 2 cycles after accept, RData=0xFFFFFFF4, mRD high exactly 1 cycle.
  - LBU Addr=0x13 -> RData=0x000000F4.
  - LH Addr=0x10 -> RData=0xFFFFA1B2.
- Byte store: word index 4 = 0x11223344; SB Addr=0x12, WData=0x000000EE -> RD then WR, mWR high exactly 1 cycle, DataIn=0x1122EE44, Done 3 cycles after accept; a following LW 0x10 returns 0x1122EE44.
- Word store/load: SW Addr=0x20, WData=0xDEADBEEF, then LW 0x20 issued on the first ReqReady -> RData=0xDEADBEEF, DataAddr=0x00000008.
- Misaligned: LH Addr=0x13 and SW Addr=0x22 -> Done=1 with AlignErr=1 one cycle after accept, mRD=mWR=0 throughout, memory unchanged.
- Reset mid-store: Reset pulled low in the WR cycle of SH Addr=0x10, before the negedge -> mWR=0 immediately, memory word unchanged, all outputs 0, ReqReady=1 after release.
- Busy handling: ReqValid held high with varying MemOp during a busy period -> only the first request executes, ReqReady=0 until IDLE.
